sha256_stream_hasher: RTL

//  Multi-block SHA-256 engine on 512-bit AXI4-Stream. Takes pre-padded 512-bit message blocks
//  on rd_*, chains the compression state across beats until tlast, then emits one digest beat
//  on wr_*. Successor to the single-block hasher in the user-logic path: adds message chaining,
//  a parametrised round unroll, and output backpressure handling.

---
 rtl/sha256_stream_hasher.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/sha256_stream_hasher.sv
// sha256_stream_hasher: multi-block SHA-256 engine on a 512-bit AXI4-Stream.
// Pre-padded 512-bit blocks arrive on rd_*. The compression state is chained across
// beats until rd_tlast, and then one digest beat is emitted on wr_*.
// ROUNDS_PER_CYCLE (1, 2 or 4) rounds are evaluated per clock.
// Optional feature: define SHA224_MODE_EN to add the mode_224 input. That input selects
// the SHA-224 IV and the truncated digest for a message.
module sha256_stream_hasher #(
  parameter int unsigned DATA_BITS        = 512,
  parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
`ifdef SHA224_MODE_EN
  input  logic                 mode_224,
`endif
  input  logic [DATA_BITS-1:0] rd_tdata,
  input  logic                 rd_tvalid,
  output logic                 rd_tready,
  input  logic                 rd_tlast,
  output logic [DATA_BITS-1:0] wr_tdata,
  output logic                 wr_tvalid,
  input  logic                 wr_tready,
  output logic                 wr_tlast
);

  if (DATA_BITS != 512) begin : g_bad_data_bits
    $error("sha256_stream_hasher: DATA_BITS must be 512");
  end
  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4)
  begin : g_bad_rounds
    $error("sha256_stream_hasher: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRound = 2'd1;
  localparam logic [1:0] StAdd   = 2'd2;
  localparam logic [1:0] StOut   = 2'd3;

  localparam logic [5:0] TStep = 6'(ROUNDS_PER_CYCLE);
  localparam logic [5:0] TLast = 6'(64 - ROUNDS_PER_CYCLE);

  // Word j of each IV sits at bits [32*j +: 32].
  localparam logic [255:0] Iv256 = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [255:0] Iv224 = {
    32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
    32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [255:0] iv_for(input logic m);
    return m ? Iv224 : Iv256;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [5:0]        t_q, t_d;
  logic [15:0][31:0] w_q, w_d;       // schedule window, w_q[0] is W[t]
  logic [7:0][31:0]  v_q, v_d;       // working variables, index 0 = a
  logic [7:0][31:0]  h_q, h_d;       // chained hash state
  logic [255:0]      dout_q, dout_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              mode_q, mode_d;
  logic              wr_valid_q, wr_valid_d;
  logic              alive_q;

  logic [15:0][31:0] rw;
  logic [7:0][31:0]  rv, base, sum;
  logic [31:0]       t1, t2, wn;
  logic              mode_in, hs;

`ifdef SHA224_MODE_EN
  assign mode_in = mode_224;
`else
  assign mode_in = 1'b0;
`endif

  // Ready only in IDLE, and never before the first clock after reset release.
  assign rd_tready = alive_q & (state_q == StIdle);
  assign hs        = rd_tvalid & rd_tready;
  assign wr_tvalid = wr_valid_q;
  assign wr_tlast  = wr_valid_q;
  assign wr_tdata  = {{(DATA_BITS - 256){1'b0}}, dout_q};

  // Unrolled rounds: working variables plus the sliding 16-word message schedule
  always_comb begin
    rv = v_q;
    rw = w_q;
    t1 = '0;
    t2 = '0;
    wn = '0;
    for (int i = 0; i < int'(ROUNDS_PER_CYCLE); i++) begin
      t1 = rv[7] + bsig1(rv[4]) + ((rv[4] & rv[5]) ^ (~rv[4] & rv[6])) + K[t_q + 6'(i)] + rw[0];
      t2 = bsig0(rv[0]) + ((rv[0] & rv[1]) ^ (rv[0] & rv[2]) ^ (rv[1] & rv[2]));
      rv = {rv[6:4], rv[3] + t1, rv[2:0], t1 + t2};
      wn = ssig1(rw[14]) + rw[9] + ssig0(rw[1]) + rw[0];
      rw = {wn, rw[15:1]};
    end
  end

  // FSM next-state and datapath loads
  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    w_d        = w_q;
    v_d        = v_q;
    h_d        = h_q;
    dout_d     = dout_q;
    first_d    = first_q;
    last_d     = last_q;
    mode_d     = mode_q;
    wr_valid_d = wr_valid_q;
    sum        = '0;
    // First block of a message adds onto the IV, not the stale chain.
    base       = first_q ? iv_for(mode_q) : h_q;
    for (int j = 0; j < 8; j++) begin
      sum[j] = base[j] + v_q[j];
    end
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          w_d     = rd_tdata[511:0];
          last_d  = rd_tlast;
          t_d     = '0;
          state_d = StRound;
          if (first_q) begin
            v_d    = iv_for(mode_in);
            mode_d = mode_in;
          end else begin
            v_d = h_q;
          end
        end
      end
      StRound: begin
        v_d = rv;
        w_d = rw;
        t_d = t_q + TStep;
        if (t_q == TLast) begin
          state_d = StAdd;
        end
      end
      StAdd: begin
        h_d = sum;
        if (last_q) begin
          dout_d     = mode_q ? {32'h0, sum[6:0]} : sum;
          wr_valid_d = 1'b1;
          state_d    = StOut;
        end else begin
          first_d = 1'b0;
          state_d = StIdle;
        end
      end
      StOut: begin
        if (wr_tready) begin
          wr_valid_d = 1'b0;
          h_d        = Iv256;
          first_d    = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any partial chain
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      t_q        <= '0;
      w_q        <= '0;
      v_q        <= '0;
      h_q        <= Iv256;
      dout_q     <= '0;
      first_q    <= 1'b1;
      last_q     <= 1'b0;
      mode_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      alive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      w_q        <= w_d;
      v_q        <= v_d;
      h_q        <= h_d;
      dout_q     <= dout_d;
      first_q    <= first_d;
      last_q     <= last_d;
      mode_q     <= mode_d;
      wr_valid_q <= wr_valid_d;
      alive_q    <= 1'b1;
    end
  end

endmodule
